// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bus: status inputs from the pipeline and the
// enable/flush/squash controls driven back to the latch bank.
interface hazard_ctrl_if;
  // Pipeline status into the controller
  logic        ihit;
  logic        dhit;
  logic        mem_req;
  logic        idex_memread;
  logic [4:0]  idex_rd;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic        ifid_uses_rt;
  logic        br_taken;
  logic        halt_wb;
  // Controls out to the latch bank
  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        mem_wb_flush;
  logic        dmem_squash;
  logic        halted;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] lu_cnt;

  // Pipeline side: drives status, observes controls
  modport master (
    output ihit, dhit, mem_req, idex_memread, idex_rd, ifid_rs, ifid_rt, ifid_uses_rt,
           br_taken, halt_wb,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
           ex_mem_flush, mem_wb_flush, dmem_squash, halted, stall_cnt, flush_cnt, lu_cnt
  );

  // Controller side
  modport slave (
    input  ihit, dhit, mem_req, idex_memread, idex_rd, ifid_rs, ifid_rt, ifid_uses_rt,
           br_taken, halt_wb,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
           ex_mem_flush, mem_wb_flush, dmem_squash, halted, stall_cnt, flush_cnt, lu_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, load-use bubble, redirect
// flush and halt retirement for a 5-stage pipeline latch bank.
// Optional macro HAZARD_PERF_EN builds saturating stall/flush/load-use
// performance counters; without it the counter ports read 0.
module hazard_ctrl (
  input  logic        CLK,
  input  logic        RST,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StRun, StDwait, StDdone, StHalt} state_e;

  state_e state_q, state_d;
  logic   pend_q, pend_d;
  logic   adv;
  logic   load_use;
  logic   redirect;

  // Pipeline may advance when fetch completes and no data access is still outstanding
  always_comb begin
    adv = 1'b0;
    unique case (state_q)
      StRun:   adv = bus.ihit & ~(bus.mem_req & ~bus.dhit);
      StDwait: adv = bus.ihit & bus.dhit;
      StDdone: adv = bus.ihit;
      StHalt:  adv = 1'b0;
      default: adv = 1'b0;
    endcase
  end

  // Load in ID/EX feeding a source of the instruction in IF/ID (r0 never hazards)
  always_comb begin
    load_use = bus.idex_memread && (bus.idex_rd != 5'd0) &&
               ((bus.idex_rd == bus.ifid_rs) ||
                (bus.ifid_uses_rt && (bus.idex_rd == bus.ifid_rt)));
  end

  assign redirect = bus.br_taken | pend_q;

  // State and pending-redirect registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StRun;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Next state; halt retirement wins over data-access tracking
  always_comb begin
    state_d = state_q;
    if (state_q != StHalt && bus.halt_wb) begin
      state_d = StHalt;
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.mem_req && !bus.dhit)                    state_d = StDwait;
          else if (bus.mem_req && bus.dhit && !bus.ihit)   state_d = StDdone;
          else                                             state_d = StRun;
        end
        StDwait: begin
          if (bus.dhit && bus.ihit)       state_d = StRun;
          else if (bus.dhit && !bus.ihit) state_d = StDdone;
          else                            state_d = StDwait;
        end
        StDdone: state_d = bus.ihit ? StRun : StDdone;
        StHalt:  state_d = StHalt;
        default: state_d = StRun;
      endcase
    end
  end

  // Remember a redirect seen while frozen; any advance consumes it
  always_comb begin
    pend_d = pend_q;
    if (adv)               pend_d = 1'b0;
    else if (bus.br_taken) pend_d = 1'b1;
  end

  // Latch controls; everything reads 0 while reset is held
  always_comb begin
    bus.pc_en        = 1'b0;
    bus.if_id_en     = 1'b0;
    bus.id_ex_en     = 1'b0;
    bus.ex_mem_en    = 1'b0;
    bus.mem_wb_en    = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_flush = 1'b0;
    bus.mem_wb_flush = 1'b0;
    bus.dmem_squash  = 1'b0;
    bus.halted       = 1'b0;
    if (!RST) begin
      bus.dmem_squash = (state_q == StDdone);
      if (state_q == StHalt) begin
        bus.halted = 1'b1;
      end else if (!adv) begin
        // Frozen: push a bubble into WB so the MEM/WB entry is not written back twice
        bus.mem_wb_en    = 1'b1;
        bus.mem_wb_flush = 1'b1;
      end else if (redirect) begin
        bus.pc_en        = 1'b1;
        bus.if_id_en     = 1'b1;
        bus.id_ex_en     = 1'b1;
        bus.ex_mem_en    = 1'b1;
        bus.mem_wb_en    = 1'b1;
        bus.if_id_flush  = 1'b1;
        bus.id_ex_flush  = 1'b1;
        bus.ex_mem_flush = 1'b1;
      end else if (load_use) begin
        bus.id_ex_en    = 1'b1;
        bus.id_ex_flush = 1'b1;
        bus.ex_mem_en   = 1'b1;
        bus.mem_wb_en   = 1'b1;
      end else begin
        bus.pc_en     = 1'b1;
        bus.if_id_en  = 1'b1;
        bus.id_ex_en  = 1'b1;
        bus.ex_mem_en = 1'b1;
        bus.mem_wb_en = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, lu_cnt_q;
  logic        stall_inc, flush_inc, lu_inc;

  assign stall_inc = (state_q != StHalt) & ~adv;
  assign flush_inc = adv & redirect;
  assign lu_inc    = adv & ~redirect & load_use;

  // Saturating performance counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      if (stall_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_inc && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (lu_inc && lu_cnt_q != '1)       lu_cnt_q    <= lu_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.lu_cnt    = lu_cnt_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
  assign bus.lu_cnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random stimulus
// checked against a flag-based behavioural model of the pipeline controller.
module tb_hazard_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  hazard_ctrl_if bus ();

  hazard_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    bit       ihit;
    bit       dhit;
    bit       mem_req;
    bit       memread;
    bit [4:0] rd;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       uses_rt;
    bit       br;
    bit       halt;
  } stim_t;

  typedef struct packed {
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        mem_wb_flush;
    logic        dmem_squash;
    logic        halted;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] lu_cnt;
  } out_t;

  out_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Model: halted, data access outstanding, data done but fetch pending, redirect owed
  bit          m_halted, m_outst, m_done, m_owed;
  logic [31:0] m_stall, m_flush, m_lu;

  always @(posedge CLK) cycle++;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic bit m_adv(input stim_t s);
    bit data_ok;
    if (m_done)                     data_ok = 1'b1;
    else if (m_outst || s.mem_req)  data_ok = s.dhit;
    else                            data_ok = 1'b1;
    return !m_halted && s.ihit && data_ok;
  endfunction

  function automatic bit m_load_use(input stim_t s);
    return s.memread && s.rd != 5'd0 && (s.rd == s.rs || (s.uses_rt && s.rd == s.rt));
  endfunction

  function automatic out_t model_out(input stim_t s);
    out_t o;
    bit   adv, redir;
    o = '0;
    if (RST) return o;
    adv   = m_adv(s);
    redir = s.br || m_owed;
    o.stall_cnt = m_stall;
    o.flush_cnt = m_flush;
    o.lu_cnt    = m_lu;
    o.dmem_squash = !m_halted && m_done;
    if (m_halted) begin
      o.halted = 1'b1;
    end else if (!adv) begin
      o.mem_wb_en = 1'b1; o.mem_wb_flush = 1'b1;
    end else if (redir) begin
      {o.pc_en, o.if_id_en, o.id_ex_en, o.ex_mem_en, o.mem_wb_en} = 5'b11111;
      {o.if_id_flush, o.id_ex_flush, o.ex_mem_flush} = 3'b111;
    end else if (m_load_use(s)) begin
      o.id_ex_en = 1'b1; o.id_ex_flush = 1'b1; o.ex_mem_en = 1'b1; o.mem_wb_en = 1'b1;
    end else begin
      {o.pc_en, o.if_id_en, o.id_ex_en, o.ex_mem_en, o.mem_wb_en} = 5'b11111;
    end
    return o;
  endfunction

  task automatic model_reset();
    m_halted = 0; m_outst = 0; m_done = 0; m_owed = 0;
    m_stall = '0; m_flush = '0; m_lu = '0;
  endtask

  task automatic model_update(input stim_t s);
    bit adv, redir;
    if (RST) begin
      model_reset();
      return;
    end
    adv   = m_adv(s);
    redir = s.br || m_owed;
`ifdef HAZARD_PERF_EN
    if (!m_halted && !adv)                 m_stall = sat_inc(m_stall);
    if (adv && redir)                      m_flush = sat_inc(m_flush);
    if (adv && !redir && m_load_use(s))    m_lu    = sat_inc(m_lu);
`endif
    if (adv)       m_owed = 0;
    else if (s.br) m_owed = 1;
    if (!m_halted && s.halt) begin
      m_halted = 1;
    end else if (!m_halted) begin
      if (m_done) begin
        m_done = !s.ihit;
      end else if (m_outst || s.mem_req) begin
        if (!s.dhit) begin
          m_outst = 1;
        end else begin
          m_outst = 0;
          m_done  = !s.ihit;
        end
      end
    end
  endtask

  function automatic out_t actual();
    out_t a;
    a.pc_en        = bus.pc_en;
    a.if_id_en     = bus.if_id_en;
    a.id_ex_en     = bus.id_ex_en;
    a.ex_mem_en    = bus.ex_mem_en;
    a.mem_wb_en    = bus.mem_wb_en;
    a.if_id_flush  = bus.if_id_flush;
    a.id_ex_flush  = bus.id_ex_flush;
    a.ex_mem_flush = bus.ex_mem_flush;
    a.mem_wb_flush = bus.mem_wb_flush;
    a.dmem_squash  = bus.dmem_squash;
    a.halted       = bus.halted;
    a.stall_cnt    = bus.stall_cnt;
    a.flush_cnt    = bus.flush_cnt;
    a.lu_cnt       = bus.lu_cnt;
    return a;
  endfunction

  task automatic check(input string name, input out_t got, input out_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %h want %h", name, cycle, got, want);
    end
  endtask

  task automatic drive(input stim_t s);
    bus.ihit         = s.ihit;
    bus.dhit         = s.dhit;
    bus.mem_req      = s.mem_req;
    bus.idex_memread = s.memread;
    bus.idex_rd      = s.rd;
    bus.ifid_rs      = s.rs;
    bus.ifid_rt      = s.rt;
    bus.ifid_uses_rt = s.uses_rt;
    bus.br_taken     = s.br;
    bus.halt_wb      = s.halt;
  endtask

  // One clock of stimulus: drive at negedge, queue expectation, advance model at posedge
  task automatic step(input stim_t s);
    @(negedge CLK);
    drive(s);
    sb_q.push_back(model_out(s));
    @(posedge CLK);
    model_update(s);
  endtask

  task automatic apply_reset();
    stim_t s;
    s = '0;
    @(negedge CLK);
    RST = 1'b1;
    drive(s);
    sb_q.push_back(model_out(s));
    @(posedge CLK);
    model_update(s);
    #1 RST = 1'b0;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.ihit = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.ihit    = ($urandom_range(0, 3) != 0);
    s.dhit    = ($urandom_range(0, 1) != 0);
    s.mem_req = ($urandom_range(0, 2) == 0);
    s.memread = ($urandom_range(0, 2) == 0);
    s.rd      = 5'($urandom_range(0, 3));
    s.rs      = 5'($urandom_range(0, 3));
    s.rt      = 5'($urandom_range(0, 3));
    s.uses_rt = ($urandom_range(0, 1) != 0);
    s.br      = ($urandom_range(0, 7) == 0);
    s.halt    = ($urandom_range(0, 149) == 0);
    return s;
  endfunction

  // Monitor: outputs are presented every cycle; compare against the oldest expectation
  initial begin
    out_t want;
    forever begin
      @(negedge CLK);
      #2;
      if (sb_q.size() != 0) begin
        want = sb_q.pop_front();
        check("outputs", actual(), want);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle %0d got timeout want finish", cycle);
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    model_reset();
    drive('0);
    apply_reset();

    // Load-use bubble, then release; r0 destination never stalls
    s = idle(); s.memread = 1; s.rd = 5; s.rs = 5;
    step(s);
    step(idle());
    s.rd = 0; s.rs = 0;
    step(s);
    s = idle(); s.memread = 1; s.rd = 7; s.rt = 7; s.uses_rt = 1;
    step(s);

    // Data wait: three frozen cycles, advance on the fourth
    s = idle(); s.mem_req = 1;
    repeat (3) step(s);
    s.dhit = 1;
    step(s);
    step(idle());

    // Data done before fetch: squash until ihit
    s = '0; s.mem_req = 1; s.dhit = 1;
    step(s);
    s.dhit = 0;
    step(s);
    s.ihit = 1;
    step(s);
    step(idle());

    // Redirect while frozen is remembered; redirect beats load-use
    s = '0; s.br = 1;
    step(s);
    s.br = 0;
    step(s);
    step(idle());
    s = idle(); s.br = 1; s.memread = 1; s.rd = 3; s.rs = 3;
    step(s);
    step(idle());

    // Halt is sticky regardless of hits
    s = idle(); s.halt = 1;
    step(s);
    repeat (4) step(rand_stim());
    apply_reset();

    // Async reset in the middle of a data wait
    s = idle(); s.mem_req = 1;
    step(s);
    step(s);
    @(negedge CLK);
    drive(s);
    #3;
    check("pre_reset_freeze", actual(), model_out(s));
    RST = 1'b1;
    #1;
    check("async_reset", actual(), '0);
    @(posedge CLK);
    model_update(s);
    #1 RST = 1'b0;
    step(idle());
    step(idle());

    // Random segments, each closed by a reset
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 200; i++) step(rand_stim());
      apply_reset();
    end

    repeat (2) @(negedge CLK);
    #5;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control block that drives the enable and flush inputs of the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It sits directly upstream of the latch bank. It combines instruction/data memory wait handling, load-use interlock, taken-branch/jump redirect flushing and halt retirement. A small FSM tracks multi-cycle data accesses so a completed data access is never re-issued while fetch is still pending.

## Interface
- No parameters.
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- mem_req  in  1  EX/MEM holds a load or store (dREN|dWEN)
- idex_memread  in  1  ID/EX holds a load
- idex_rd  in  5  destination register of the load in ID/EX
- ifid_rs, ifid_rt  in  5 each  source registers of the instruction in IF/ID
- ifid_uses_rt  in  1  IF/ID instruction reads rt
- br_taken  in  1  redirect (taken branch, j, jal, jr) resolved from EX/MEM
- halt_wb  in  1  MEM/WB holds halt
- pc_en  out  1  PC update enable
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  latch enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  latch flushes (load bubble)
- dmem_squash  out  1  drop the data request; access already completed
- halted  out  1  sticky halt indication
- stall_cnt, flush_cnt, lu_cnt  out  32 each  performance counters (see Configuration)

## Operation
- FSM states: RUN, DWAIT, DDONE, HALT. Reset state RUN. Redirect-pending flag `pend`, reset 0.
- Transitions, evaluated in priority order:
  - Any state except HALT, halt_wb=1 -> HALT.
  - RUN: mem_req&~dhit -> DWAIT; mem_req&dhit&~ihit -> DDONE; else RUN.
  - DWAIT: dhit&ihit -> RUN; dhit&~ihit -> DDONE; else DWAIT.
  - DDONE: ihit -> RUN; else DDONE.
  - HALT: stays until RST.
- Advance condition `adv`:
  - RUN: ihit & ~(mem_req&~dhit)
  - DWAIT: ihit&dhit
  - DDONE: ihit
  - HALT: 0
- Outputs, evaluated in priority order:
  - HALT: all enables 0, all flushes 0, halted=1.
  - ~adv (freeze): pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_en=1 and mem_wb_flush=1, so a bubble enters WB and no double writeback occurs.
  - adv & (br_taken|pend): all enables 1; if_id_flush, id_ex_flush, ex_mem_flush = 1. Redirect overrides load-use.
  - adv & load-use: pc_en=0, if_id_en=0; id_ex_en=1 with id_ex_flush=1; ex_mem_en=1, mem_wb_en=1.
    - Load-use is defined as idex_memread & idex_rd≠0 & (idex_rd==ifid_rs | (ifid_uses_rt & idex_rd==ifid_rt)).
  - Otherwise: all enables 1, no flush.
- Flush is never asserted with its enable low.
- dmem_squash=1 exactly while in DDONE.
- pend: set on the clock edge where br_taken=1 & ~adv; cleared on any adv edge. Simultaneous set and clear resolves to clear.

## Timing
- Enables, flushes and dmem_squash are combinational from the state, pend and inputs. They take effect at the next CLK edge in the latches.
- Load-use costs exactly 1 bubble cycle. Redirect costs 3 squashed slots.
- Data access with latency N cycles (dhit on cycle N) and ihit present: pipe frozen N-1 cycles, advances on cycle N.
- While RST=1, all outputs are 0, counters are 0, state is RUN and pend is 0. This applies asynchronously, including mid-DWAIT or in HALT.
- halted rises the cycle after halt_wb is sampled.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments each cycle in which the state is not HALT and adv=0.
  - flush_cnt increments on each adv redirect cycle.
  - lu_cnt increments on each load-use bubble.
  - All counters saturate at 0xFFFF_FFFF.
- HAZARD_PERF_EN undefined: the three ports remain and are tied to 0; no counter flops are built.

## Test plan
- Load-use: idex_memread=1, idex_rd=5, ifid_rs=5, ihit=1, no mem_req -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1. idex_rd=0 gives no stall.
- Data wait: mem_req=1, dhit low 3 cycles then high, ihit=1 throughout -> 3 freeze cycles (mem_wb_flush=1), advance on the 4th; stall_cnt=3 with the macro.
- DDONE: mem_req=1, dhit=1, ihit=0 -> next cycle dmem_squash=1 and frozen; ihit on cycle 3 -> advance, return to RUN, dmem_squash=0.
- Redirect during freeze: br_taken pulse while ihit=0, then ihit=1 with br_taken=0 -> pend holds, flushes fire on the ihit cycle, flush_cnt=1. Redirect with simultaneous load-use -> redirect outputs only.
- Halt: halt_wb=1 -> halted=1 next cycle, all enables 0 regardless of ihit/dhit, until RST.
- Async reset asserted in DWAIT mid-cycle -> outputs 0 immediately; after release, state RUN with counters 0.
